// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, control states, ALU selects and width defaults shared by the accumulator CPU.
package cpu_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_JMP   = 4'd5;
  localparam logic [3:0] OP_JZ    = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd7;
  typedef enum logic [2:0] {FETCH0, FETCH1, FETCH2, DECODE, EXEC_RD, EXEC_ALU, EXEC_WR, HALT} state_t;
  typedef enum logic [1:0] {ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND} alu_op_t;
  function automatic alu_op_t alu_sel(input logic [3:0] op);
    return op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : ALU_PASS;
  endfunction
  function automatic logic is_mem_rd(input logic [3:0] op);
    return op inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND};
  endfunction
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational accumulator ALU (pass/add/sub/and, modulo 2^DATA_W) with zero detect.
module cpu_alu import cpu_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zero
);
  always_comb begin
    y = op == ALU_ADD ? a + b : op == ALU_SUB ? a - b : op == ALU_AND ? a & b : b;
    zero = y == '0;
  end
endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle fetch/decode/execute sequencer driving the register bank next values and the memory handshake.
module cpu_control_fsm import cpu_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC_reg,
  output logic [ADDR_W-1:0] PC_next,
  input  logic [DATA_W-1:0] IR_reg,
  output logic [DATA_W-1:0] IR_next,
  input  logic [DATA_W-1:0] ACC_reg,
  output logic [DATA_W-1:0] ACC_next,
  input  logic [DATA_W-1:0] MDR_reg,
  output logic [DATA_W-1:0] MDR_next,
  input  logic [ADDR_W-1:0] MAR_reg,
  output logic [ADDR_W-1:0] MAR_next,
  input  logic              zflag_reg,
  output logic              zflag_next,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              instr_done
);
  state_t state;
  logic [3:0] op;
  logic [ADDR_W-1:0] opnd;
  logic [DATA_W-1:0] alu_y;
  logic alu_z;
  logic unused_ir;
  assign op = IR_reg[15:12];
  assign opnd = ADDR_W'(IR_reg[7:0]);
  assign unused_ir = ^IR_reg[11:8];
  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op(alu_sel(op)),
    .a(ACC_reg),
    .b(MDR_reg),
    .y(alu_y),
    .zero(alu_z)
  );
  // reset wins over any pending handshake, so a late mem_ready can never advance an aborted transfer
  always_ff @(posedge clk)
    if (rst) state <= FETCH0;
    else
      case (state)
        FETCH0:   state <= FETCH1;
        FETCH1:   state <= mem_ready ? FETCH2 : FETCH1;
        FETCH2:   state <= DECODE;
        DECODE:   state <= is_mem_rd(op) ? EXEC_RD : op == OP_STORE ? EXEC_WR : op == OP_HALT ? HALT : FETCH0;
        EXEC_RD:  state <= mem_ready ? EXEC_ALU : EXEC_RD;
        EXEC_ALU: state <= FETCH0;
        EXEC_WR:  state <= mem_ready ? FETCH0 : EXEC_WR;
        HALT:     state <= HALT;
      endcase
  assign mem_req = state inside {FETCH1, EXEC_RD, EXEC_WR};
  assign mem_we = state == EXEC_WR;
  assign mem_addr = MAR_reg;
  assign mem_wdata = MDR_reg;
  assign halted = state == HALT;
  assign instr_done = state == EXEC_ALU || (state == EXEC_WR && mem_ready) ||
                      (state == DECODE && !is_mem_rd(op) && op != OP_STORE && op != OP_HALT);
  always_comb begin
    PC_next = PC_reg;
    IR_next = IR_reg;
    ACC_next = ACC_reg;
    MDR_next = MDR_reg;
    MAR_next = MAR_reg;
    zflag_next = zflag_reg;
    case (state)
      FETCH0: MAR_next = PC_reg;
      FETCH1: begin
        MDR_next = mem_ready ? mem_rdata : MDR_reg;
        PC_next = mem_ready ? PC_reg + ADDR_W'(1) : PC_reg;
      end
      FETCH2: IR_next = MDR_reg;
      DECODE: begin
        MAR_next = opnd;
        MDR_next = op == OP_STORE ? ACC_reg : MDR_reg;
        PC_next = (op == OP_JMP || (op == OP_JZ && zflag_reg)) ? opnd : PC_reg;
      end
      EXEC_RD: MDR_next = mem_ready ? mem_rdata : MDR_reg;
      EXEC_ALU: begin
        ACC_next = alu_y;
        zflag_next = alu_z;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control unit for the accumulator CPU. It sequences the shared PC/IR/ACC/MDR/MAR/zflag register bank through fetch, decode and execute. It reads the current register values, drives every `*_next` input of the register bank, and owns the single-port memory request/ready handshake. It sits between the register bank and the memory, one instance per core.

## Interface
Parameters:
- `ADDR_W`, default 8: address width of PC, MAR and `mem_addr`.
- `DATA_W`, default 16: width of IR, ACC, MDR and memory data.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `PC_reg` / `PC_next`, in / out, ADDR_W: program counter, current value and next value.
- `IR_reg` / `IR_next`, in / out, DATA_W: instruction register.
- `ACC_reg` / `ACC_next`, in / out, DATA_W: accumulator.
- `MDR_reg` / `MDR_next`, in / out, DATA_W: memory data register.
- `MAR_reg` / `MAR_next`, in / out, ADDR_W: memory address register.
- `zflag_reg` / `zflag_next`, in / out, 1: zero flag.
- `mem_req`, out, 1: memory request; held high until `mem_ready` is seen.
- `mem_we`, out, 1: write enable, qualified by `mem_req`.
- `mem_addr`, out, ADDR_W: always equal to `MAR_reg`.
- `mem_wdata`, out, DATA_W: always equal to `MDR_reg`.
- `mem_rdata`, in, DATA_W: read data, valid in the cycle `mem_ready` is high.
- `mem_ready`, in, 1: transaction completes in the cycle it is sampled high while `mem_req` is high.
- `halted`, out, 1: high while in the HALT state.
- `instr_done`, out, 1: one-cycle pulse on the final cycle of every instruction except HALT.

## Operation
- Instruction format: `IR[15:12]` opcode, `IR[7:0]` operand address.
- Opcodes:
  - 0 LOAD: ACC = mem[a].
  - 1 STORE: mem[a] = ACC.
  - 2 ADD: ACC += mem[a].
  - 3 SUB: ACC -= mem[a].
  - 4 AND: ACC &= mem[a].
  - 5 JMP: PC = a.
  - 6 JZ: PC = a if zflag.
  - 7 HALT.
  - 8–15: NOP.
- Default for every `*_next` output in every state is to equal the matching `*_reg` (hold). Only the updates listed below deviate from hold.
- States and transitions:
  - FETCH0: MAR_next = PC. Go to FETCH1.
  - FETCH1: `mem_req`=1, `mem_we`=0. On `mem_ready`: MDR_next = `mem_rdata`, PC_next = PC+1, go to FETCH2. Otherwise stay.
  - FETCH2: IR_next = MDR. Go to DECODE.
  - DECODE: MAR_next = IR[7:0].
    - LOAD/ADD/SUB/AND: go to EXEC_RD.
    - STORE: MDR_next = ACC, go to EXEC_WR.
    - JMP: PC_next = IR[7:0], `instr_done`, go to FETCH0.
    - JZ: PC_next = IR[7:0] only if `zflag_reg`=1; `instr_done`; go to FETCH0.
    - HALT: go to HALT.
    - NOP: `instr_done`, go to FETCH0.
  - EXEC_RD: `mem_req`=1, `mem_we`=0. On `mem_ready`: MDR_next = `mem_rdata`, go to EXEC_ALU.
  - EXEC_ALU: ACC_next = alu(op, ACC, MDR); zflag_next = (ACC_next == 0); `instr_done`; go to FETCH0.
  - EXEC_WR: `mem_req`=1, `mem_we`=1. On `mem_ready`: `instr_done`, go to FETCH0.
  - HALT: all registers hold, `mem_req`=0. Leave only on `rst`.
- Arithmetic:
  - ADD and SUB are modulo 2^DATA_W; no carry or borrow is kept.
  - PC increment wraps from 0xFF to 0x00.
- zflag changes only in EXEC_ALU. It is not touched by STORE, JMP or JZ.

## Timing
- Reset: state = FETCH0; `mem_req`=0, `mem_we`=0, `halted`=0, `instr_done`=0. In the cycle after reset is released, `*_next` outputs reflect FETCH0 (MAR_next = PC_reg).
- Reset during any state, including one with a memory transaction pending, aborts immediately. The pending `mem_ready` is ignored. `mem_req` is low in the cycle after `rst` is sampled.
- Instruction latency in cycles, with zero-wait memory (ready in the first request cycle):
  - LOAD/ADD/SUB/AND: 6.
  - STORE: 5.
  - JMP/JZ/NOP: 4.
- Each wait cycle on `mem_ready` adds one cycle. Wait counts are unbounded.
- `mem_req` never drops before `mem_ready` is seen. `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req` is high.
- `mem_ready` outside FETCH1, EXEC_RD or EXEC_WR is ignored.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode localparams;
  - the state enum (FETCH0, FETCH1, FETCH2, DECODE, EXEC_RD, EXEC_ALU, EXEC_WR, HALT);
  - the `ADDR_W`/`DATA_W` defaults.
- One sub-module, `cpu_alu`: combinational ADD/SUB/AND/pass-through (LOAD) plus the zero output.
- The FSM state register is the only flop in this block. All datapath storage stays in the register bank.

## Test plan
- Reset, then run `mem[0]=0x0010` (LOAD 0x10) with `mem[0x10]=0x1234` and zero-wait memory → ACC=0x1234, zflag=0, PC=1, `instr_done` in cycle 6.
- Run ADD with ACC=0xFFFF and `mem[a]`=0x0001 → ACC=0x0000, zflag=1. Follow with JZ 0x40 → PC=0x40 after 4 cycles.
- Run STORE 0x20 with ACC=0xBEEF and 3 wait cycles → exactly one write beat with `mem_addr`=0x20, `mem_wdata`=0xBEEF, `mem_we`=1; `mem_req` high for 4 cycles; latency 8.
- Fetch from PC=0xFF with a NOP (0x8000) → PC wraps to 0x00. Also run JZ with zflag=0 → PC=next sequential address.
- Run HALT (0x7000) → `halted`=1 and `mem_req` stays 0 for 20 cycles; `rst` then returns the FSM to FETCH0 with PC=0.
- Assert `rst` in EXEC_RD while `mem_ready` is low → next cycle `mem_req`=0; a late `mem_ready` pulse changes no register.
